// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared types and defaults for the multi-port register file.
// Holds the clear-sequencer state encoding and the default array geometry.

package regfile_mp_pkg;

   // Clear sequencer states: zeroing the array, or open for normal traffic.
   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rf_state_e;

   localparam int RF_DEFAULT_WIDTH = 16;
   localparam int RF_DEFAULT_DEPTH = 8;

endpackage : regfile_mp_pkg

// File: rtl/regfile_mp_clear_seq.sv
// regfile_mp_clear_seq: walks every register index once, issuing zero writes,
// after reset and whenever a clear is requested. ready stays low until the
// last index has been written.

module regfile_mp_clear_seq
   import regfile_mp_pkg::*;
#(
   parameter int DEPTH = RF_DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr,
   output logic          ready
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   rf_state_e     state;
   logic [AW-1:0] clr_idx;

   // Clear FSM: a clear request always restarts the sweep from index 0,
   // whatever the current state; the last zero write hands over to READY.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
         clr_we  <= 1'b1;
         ready   <= 1'b0;
      end else if (clear) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
         clr_we  <= 1'b1;
         ready   <= 1'b0;
      end else begin
         case (state)
            RF_CLEAR: begin
               if (clr_idx == LAST_IDX) begin
                  state   <= RF_READY;
                  clr_idx <= '0;
                  clr_we  <= 1'b0;
                  ready   <= 1'b1;
               end else begin
                  clr_idx <= clr_idx + AW'(1);
               end
            end
            RF_READY: begin
               clr_we <= 1'b0;
               ready  <= 1'b1;
            end
            default: begin
               state   <= RF_CLEAR;
               clr_idx <= '0;
               clr_we  <= 1'b1;
               ready   <= 1'b0;
            end
         endcase
      end
   end

   assign clr_addr = clr_idx;

endmodule : regfile_mp_clear_seq

// File: rtl/regfile_mp.sv
// regfile_mp: WIDTH x DEPTH register file, one write port, two registered
// read ports. A clear sequencer zeroes the array after reset or on request.
// Configuration macro REGFILE_MP_BYPASS_EN: when defined, a read that hits the
// address of a write committing in the same cycle returns the new data;
// otherwise it returns the old stored value.

module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int WIDTH = RF_DEFAULT_WIDTH,
   parameter int DEPTH = RF_DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             ready
);

   // One wider than the address so non-power-of-two depths compare cleanly.
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             clr_we;
   logic [AW-1:0]    clr_addr;
   logic             user_we;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             a_in_range;
   logic             b_in_range;
   logic [WIDTH-1:0] rd_next_a;
   logic [WIDTH-1:0] rd_next_b;

   regfile_mp_clear_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready    (ready)
   );

   assign a_in_range = {1'b0, rd_addr_a} < DEPTH_W;
   assign b_in_range = {1'b0, rd_addr_b} < DEPTH_W;

   // A user write only lands when the array is clean, no clear is pending
   // this cycle (clear wins) and the index exists.
   assign user_we = wr_en & ready & ~clear & ({1'b0, wr_addr} < DEPTH_W);

   // Merge sequencer and user writes; the sequencer owns the port while
   // ready is low, so the two never compete.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      if (clr_we) begin
         mem_we    = 1'b1;
         mem_addr  = clr_addr;
         mem_wdata = '0;
      end else if (user_we) begin
         mem_we = 1'b1;
      end
   end

   // Storage write.
   // NOTE: the array deliberately has no reset; it is zeroed by the clear
   // sequencer, which keeps it mappable to plain flops or RAM without a
   // reset fan-out.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   // Next read data for port A: zero while clearing or out of range,
   // optionally forwarding a same-cycle committing write.
   always_comb begin
      rd_next_a = '0;
      if (ready && a_in_range) begin
         rd_next_a = mem[rd_addr_a];
`ifdef REGFILE_MP_BYPASS_EN
         if (user_we && (wr_addr == rd_addr_a)) begin
            rd_next_a = wr_data;
         end
`endif
      end
   end

   // Next read data for port B, same rules as port A.
   always_comb begin
      rd_next_b = '0;
      if (ready && b_in_range) begin
         rd_next_b = mem[rd_addr_b];
`ifdef REGFILE_MP_BYPASS_EN
         if (user_we && (wr_addr == rd_addr_b)) begin
            rd_next_b = wr_data;
         end
`endif
      end
   end

   // Registered read ports; reset forces both to zero immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         rd_data_a <= rd_next_a;
         rd_data_b <= rd_next_b;
      end
   end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Two instances run side by side
// (DEPTH=8 and DEPTH=6, both WIDTH=16); a behavioural model tracks the array
// contents and remaining clear sweep per instance and is compared after every
// clock edge, with literal expectations at the key points.

module tb_regfile_mp;

   localparam int W  = 16;
   localparam int AW = 3;

   logic          clk;
   logic          rst_n;
   logic          clear_i [2];
   logic          we_i    [2];
   logic [AW-1:0] wa_i    [2];
   logic [W-1:0]  wd_i    [2];
   logic [AW-1:0] ra_i    [2];
   logic [AW-1:0] rb_i    [2];
   logic [W-1:0]  rda_o   [2];
   logic [W-1:0]  rdb_o   [2];
   logic          rdy_o   [2];

   int checks = 0;
   int errors = 0;

   // Behavioural model: contents, number of clear writes still owed, reads.
   int           depth [2] = '{8, 6};
   logic [W-1:0] m_mem [2][8];
   int           m_left [2];
   logic [W-1:0] m_rda [2];
   logic [W-1:0] m_rdb [2];

   regfile_mp #(.WIDTH(16), .DEPTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear_i[0]),
      .wr_en     (we_i[0]),
      .wr_addr   (wa_i[0]),
      .wr_data   (wd_i[0]),
      .rd_addr_a (ra_i[0]),
      .rd_addr_b (rb_i[0]),
      .rd_data_a (rda_o[0]),
      .rd_data_b (rdb_o[0]),
      .ready     (rdy_o[0])
   );

   regfile_mp #(.WIDTH(16), .DEPTH(6)) dut6 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear_i[1]),
      .wr_en     (we_i[1]),
      .wr_addr   (wa_i[1]),
      .wr_data   (wd_i[1]),
      .rd_addr_a (ra_i[1]),
      .rd_addr_b (rb_i[1]),
      .rd_data_a (rda_o[1]),
      .rd_data_b (rdb_o[1]),
      .ready     (rdy_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      for (int k = 0; k < 2; k++) begin
         clear_i[k] = 1'b0;
         we_i[k]    = 1'b0;
         wa_i[k]    = '0;
         wd_i[k]    = '0;
         ra_i[k]    = '0;
         rb_i[k]    = '0;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_left[k] = depth[k];
         m_rda[k]  = '0;
         m_rdb[k]  = '0;
      end
   endtask

   function automatic logic [W-1:0] model_read(input int k, input int addr, input bit busy,
                                               input bit commit, input int waddr);
      if (busy || addr >= depth[k]) return '0;
`ifdef REGFILE_MP_BYPASS_EN
      if (commit && waddr == addr) return wd_i[k];
`endif
      return m_mem[k][addr];
   endfunction

   // Advance the model across one rising edge using the inputs applied to it.
   task automatic model_edge(input int k);
      int a, b, w;
      bit busy, commit;
      a      = int'(ra_i[k]);
      b      = int'(rb_i[k]);
      w      = int'(wa_i[k]);
      busy   = (m_left[k] > 0);
      commit = we_i[k] && !busy && !clear_i[k] && (w < depth[k]);
      m_rda[k] = model_read(k, a, busy, commit, w);
      m_rdb[k] = model_read(k, b, busy, commit, w);
      if (busy) begin
         m_mem[k][depth[k] - m_left[k]] = '0;
         m_left[k]--;
      end
      if (clear_i[k]) m_left[k] = depth[k];
      if (commit) m_mem[k][w] = wd_i[k];
   endtask

   // Single compare point: DUT outputs against the model, both instances.
   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("model_rda_d%0d", depth[k]), rda_o[k], m_rda[k]);
         check($sformatf("model_rdb_d%0d", depth[k]), rdb_o[k], m_rdb[k]);
         check($sformatf("model_ready_d%0d", depth[k]), W'(rdy_o[k]), W'(m_left[k] == 0));
      end
   endtask

   // One clock: inputs already applied; sample 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (rst_n) begin
         for (int k = 0; k < 2; k++) model_edge(k);
      end
      compare_all();
      idle();
   endtask

   // Asynchronous reset pulse between edges; outputs must clear at once.
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_rda"}, rda_o[0], 16'h0000);
      check({tag, "_ready"}, W'(rdy_o[0]), 16'h0000);
      model_reset();
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 8; i++) m_mem[k][i] = '0;
      model_reset();

      // Reset state.
      #12;
      check("rst_rda8", rda_o[0], 16'h0000);
      check("rst_rdb8", rdb_o[0], 16'h0000);
      check("rst_ready8", W'(rdy_o[0]), 16'h0000);
      check("rst_ready6", W'(rdy_o[1]), 16'h0000);
      compare_all();
      rst_n = 1'b1;

      // Initial sweep: ready at edge 8 (edge 6 for the small array).
      repeat (7) step();
      check("ready8_edge7", W'(rdy_o[0]), 16'h0000);
      check("ready6_edge7", W'(rdy_o[1]), 16'h0001);
      step();
      check("ready8_edge8", W'(rdy_o[0]), 16'h0001);

      // Every entry reads zero on both ports.
      for (int i = 0; i < 8; i++) begin
         ra_i[0] = AW'(i);
         rb_i[0] = AW'(7 - i);
         ra_i[1] = AW'(i);
         rb_i[1] = AW'(i);
         step();
      end
      check("zero_r0_a", rda_o[0], 16'h0000);

      // Write R3 then read it on both ports.
      we_i[0] = 1'b1; wa_i[0] = 3'd3; wd_i[0] = 16'hBEEF;
      step();
      ra_i[0] = 3'd3; rb_i[0] = 3'd3;
      step();
      check("beef_a", rda_o[0], 16'hBEEF);
      check("beef_b", rdb_o[0], 16'hBEEF);

      // Independent ports on different addresses.
      we_i[0] = 1'b1; wa_i[0] = 3'd1; wd_i[0] = 16'h0101;
      step();
      we_i[0] = 1'b1; wa_i[0] = 3'd6; wd_i[0] = 16'h0606;
      step();
      ra_i[0] = 3'd1; rb_i[0] = 3'd6;
      step();
      check("port_a_r1", rda_o[0], 16'h0101);
      check("port_b_r6", rdb_o[0], 16'h0606);

      // Same-cycle write and read of R5.
      we_i[0] = 1'b1; wa_i[0] = 3'd5; wd_i[0] = 16'h1234; ra_i[0] = 3'd5; rb_i[0] = 3'd3;
      step();
`ifdef REGFILE_MP_BYPASS_EN
      check("samecyc_a", rda_o[0], 16'h1234);
`else
      check("samecyc_a", rda_o[0], 16'h0000);
`endif
      check("samecyc_b", rdb_o[0], 16'hBEEF);
      ra_i[0] = 3'd5;
      step();
      check("after_a", rda_o[0], 16'h1234);

      // Write and clear together: the write is lost, array re-zeroed.
      we_i[0] = 1'b1; wa_i[0] = 3'd2; wd_i[0] = 16'h5555;
      step();
      clear_i[0] = 1'b1; we_i[0] = 1'b1; wa_i[0] = 3'd2; wd_i[0] = 16'hAAAA; ra_i[0] = 3'd2;
      step();
      check("clr_edge_ready", W'(rdy_o[0]), 16'h0000);
      check("clr_edge_read", rda_o[0], 16'h5555);
      for (int i = 0; i < 7; i++) begin
         ra_i[0] = 3'd2;
         step();
      end
      check("clr_ready_c7", W'(rdy_o[0]), 16'h0000);
      step();
      check("clr_ready_c8", W'(rdy_o[0]), 16'h0001);
      ra_i[0] = 3'd2; rb_i[0] = 3'd3;
      step();
      check("clr_r2", rda_o[0], 16'h0000);
      check("clr_r3", rdb_o[0], 16'h0000);

      // DEPTH=6: fill 0..5, writes to 6 and 7 dropped, reads of 6/7 zero.
      for (int i = 0; i < 6; i++) begin
         we_i[1] = 1'b1; wa_i[1] = AW'(i); wd_i[1] = 16'h1000 + W'(i);
         step();
      end
      we_i[1] = 1'b1; wa_i[1] = 3'd7; wd_i[1] = 16'hFFFF;
      step();
      we_i[1] = 1'b1; wa_i[1] = 3'd6; wd_i[1] = 16'hEEEE;
      step();
      ra_i[1] = 3'd6; rb_i[1] = 3'd7;
      step();
      check("d6_rd6", rda_o[1], 16'h0000);
      check("d6_rd7", rdb_o[1], 16'h0000);
      for (int i = 0; i < 6; i++) begin
         ra_i[1] = AW'(i); rb_i[1] = AW'(5 - i);
         step();
      end
      check("d6_r5", rda_o[1], 16'h1005);
      check("d6_r0", rdb_o[1], 16'h1000);

      // Clear re-asserted mid-sweep restarts the count.
      clear_i[0] = 1'b1; clear_i[1] = 1'b1;
      step();
      repeat (4) step();
      clear_i[0] = 1'b1;
      step();
      repeat (7) step();
      check("reclr_ready_c7", W'(rdy_o[0]), 16'h0000);
      step();
      check("reclr_ready_c8", W'(rdy_o[0]), 16'h0001);

      // Reset while ready with live read data.
      we_i[0] = 1'b1; wa_i[0] = 3'd4; wd_i[0] = 16'h4444;
      step();
      ra_i[0] = 3'd4;
      step();
      check("pre_rst_r4", rda_o[0], 16'h4444);
      async_reset("rst_ready");

      // Reset at clear index 3, then a full sweep.
      repeat (3) step();
      async_reset("rst_clr3");
      repeat (7) step();
      check("rst_ready_c7", W'(rdy_o[0]), 16'h0000);
      step();
      check("rst_ready_c8", W'(rdy_o[0]), 16'h0001);
      ra_i[0] = 3'd4; rb_i[0] = 3'd7;
      step();
      check("post_rst_r4", rda_o[0], 16'h0000);
      check("post_rst_r7", rdb_o[0], 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_regfile_mp
